// File: rtl/time_stamp_tagger_pkg.sv
// Shared constants and tag layout for the time stamp tagger.
// Tag = {channel mask, time}; the mask sits in the MSBs.
package time_stamp_tagger_pkg;

  localparam int TS_W_DEF   = 48;
  localparam int EV_CH_DEF  = 8;
  localparam int TAG_W_DEF  = TS_W_DEF + EV_CH_DEF;

  localparam int                  DROP_CNT_W   = 16;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_SAT = '1;

  typedef struct packed {
    logic [EV_CH_DEF-1:0] mask;
    logic [TS_W_DEF-1:0]  ts;
  } tag_t;

  function automatic int tag_width(input int ts_w, input int ev_ch);
    return ts_w + ev_ch;
  endfunction

endpackage

// File: rtl/time_stamp_tagger_fifo.sv
// tag_fifo: synchronous first-word-fall-through FIFO with full/empty/occupancy.
// A push while full is refused even when a pop happens in the same cycle.
module tag_fifo #(
  parameter int WIDTH = 56,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  // Gate the read port so the output reads zero while empty.
  assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/time_stamp_tagger.sv
// Latches CURRENT_TIME on event rising edges, buffers tags, streams them on AXIS.
// Optional packet framing (TLAST every PACKET_LEN beats) under TIME_STAMP_TAGGER_PACKET_EN.
module time_stamp_tagger
  import time_stamp_tagger_pkg::*;
#(
  parameter int TIME_STAMP_WIDTH = TS_W_DEF,
  parameter int EVENT_CH_NUM     = EV_CH_DEF,
  parameter int FIFO_DEPTH       = 16,
  parameter int PACKET_LEN       = 16
) (
  input  logic                                     CLK,
  input  logic                                     RESET,
  input  logic [TIME_STAMP_WIDTH-1:0]              CURRENT_TIME,
  input  logic [EVENT_CH_NUM-1:0]                  EVENT_IN,
  input  logic                                     CLEAR,
  output logic [TIME_STAMP_WIDTH+EVENT_CH_NUM-1:0] M_AXIS_TDATA,
  output logic                                     M_AXIS_TVALID,
  input  logic                                     M_AXIS_TREADY,
  output logic                                     M_AXIS_TLAST,
  output logic                                     OVERFLOW,
  output logic [DROP_CNT_W-1:0]                    DROP_COUNT
);
  localparam int TAG_W = tag_width(TIME_STAMP_WIDTH, EVENT_CH_NUM);

  logic [EVENT_CH_NUM-1:0] ev_prev_q;
  logic [EVENT_CH_NUM-1:0] rise;
  logic                    tag_vld, drop, hs;
  logic                    fifo_empty, fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
  logic                    ovf_q, ovf_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  assign rise    = EVENT_IN & ~ev_prev_q;
  assign tag_vld = (|rise) && (CURRENT_TIME != '0);
  assign drop    = tag_vld & fifo_full;
  assign hs      = M_AXIS_TVALID & M_AXIS_TREADY;

  // Reset to all ones so lines already high at reset release do not fire.
  always_ff @(posedge CLK) begin
    if (RESET) ev_prev_q <= '1;
    else       ev_prev_q <= EVENT_IN;
  end

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (tag_vld),
    .din_i   ({rise, CURRENT_TIME}),
    .pop_i   (M_AXIS_TREADY),
    .dout_o  (M_AXIS_TDATA),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  assign M_AXIS_TVALID = ~fifo_empty;

  // A drop in the same cycle as CLEAR wins: the cleared state is restarted at one.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (CLEAR) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (CLEAR)                          drop_cnt_d = DROP_CNT_W'(1);
      else if (drop_cnt_q != DROP_CNT_SAT) drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign OVERFLOW   = ovf_q;
  assign DROP_COUNT = drop_cnt_q;

`ifdef TIME_STAMP_TAGGER_PACKET_EN
  localparam int BEAT_W = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              beat_last;

  assign beat_last = (beat_q == BEAT_W'(PACKET_LEN - 1));

  always_comb begin
    beat_d = beat_q;
    if (hs) beat_d = beat_last ? '0 : beat_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) beat_q <= '0;
    else       beat_q <= beat_d;
  end

  assign M_AXIS_TLAST = M_AXIS_TVALID & beat_last;

  logic unused_sig;
  assign unused_sig = ^fifo_cnt;
`else
  assign M_AXIS_TLAST = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{fifo_cnt, hs, PACKET_LEN[0]};
`endif

endmodule

// File: doc/time_stamp_tagger.md
# time_stamp_tagger

Consumer of the free-running time base: latches `CURRENT_TIME` on rising edges of up to `EVENT_CH_NUM` event lines and buffers each tag in a small synchronous FIFO. Tags leave on an AXI4-Stream master port. The block sits between the time counter and the readout/DMA path. Drop accounting is provided so that a stalled downstream is visible to software.

## Interface
Parameters:
- `TIME_STAMP_WIDTH`, 48: width of `CURRENT_TIME` and the time field of each tag.
- `EVENT_CH_NUM`, 8: number of event input lines, 1..16.
- `FIFO_DEPTH`, 16: tag buffer entries, power of 2, ≥ 2.
- `PACKET_LEN`, 16: beats per packet, ≥ 1. Used only with `TIME_STAMP_TAGGER_PACKET_EN`.

Ports:
- `CLK`: in, 1. Single clock.
- `RESET`: in, 1. Synchronous, active-high.
- `CURRENT_TIME`: in, `TIME_STAMP_WIDTH`. Time base from the counter. A value of 0 means the time base is not running.
- `EVENT_IN`: in, `EVENT_CH_NUM`. Level event lines, synchronous to `CLK`.
- `CLEAR`: in, 1. Single-cycle pulse; clears `OVERFLOW` and `DROP_COUNT`.
- `M_AXIS_TDATA`: out, `TIME_STAMP_WIDTH+EVENT_CH_NUM`. Carries {channel mask, time}; the mask occupies the MSBs.
- `M_AXIS_TVALID`: out, 1.
- `M_AXIS_TREADY`: in, 1.
- `M_AXIS_TLAST`: out, 1.
- `OVERFLOW`: out, 1. Sticky; set when a tag is dropped.
- `DROP_COUNT`: out, 16. Count of dropped tags, saturating.

## Operation
- Edge detect: `rise = EVENT_IN & ~ev_prev`. `ev_prev` is registered every cycle.
- A tag is generated in a cycle when `rise != 0` and `CURRENT_TIME != 0`. All channels rising in the same cycle share one tag; the mask carries all of them.
- A rise while `CURRENT_TIME == 0` is ignored. It is not counted as a drop.
- Write: the tag {rise, `CURRENT_TIME`} is written at the clock edge that samples the rise, if the FIFO is not full.
- Full: the write is refused whenever occupancy equals `FIFO_DEPTH` at that edge, even if a pop happens in the same cycle. On a refused write, `OVERFLOW` is set and `DROP_COUNT` increments, saturating at 0xFFFF.
- `CLEAR` and a drop in the same cycle: the drop wins. `OVERFLOW` ends at 1 and `DROP_COUNT` ends at 1.
- Output: first-word-fall-through. `M_AXIS_TVALID` is high whenever the FIFO is non-empty. A pop occurs on `TVALID & TREADY`.
- AXIS rule: once `TVALID` is asserted, `TDATA` and `TLAST` hold stable until the handshake.
- Simultaneous push and pop when not full: both take effect and occupancy is unchanged.
- Pointers are `log2(FIFO_DEPTH)` bits and wrap naturally. Occupancy is `log2(FIFO_DEPTH)+1` bits.

## Timing
- Reset values:
  - `M_AXIS_TVALID`=0, `M_AXIS_TDATA`=0, `M_AXIS_TLAST`=0.
  - `OVERFLOW`=0, `DROP_COUNT`=0.
  - FIFO empty, beat counter 0.
  - `ev_prev` = all ones, so lines held high across reset do not fire.
- Latency: with `EVENT_IN` rising in cycle c into an empty FIFO, `TVALID`=1 in cycle c+1. `TDATA` time equals `CURRENT_TIME` of cycle c.
- Throughput: one tag per cycle in and one beat per cycle out.
- Reset asserted mid-operation flushes all buffered tags in the same edge. Output is invalid from the next cycle.

## Configuration
- Macro: `TIME_STAMP_TAGGER_PACKET_EN`.
- Defined: a beat counter (0..`PACKET_LEN`-1) advances on each handshake. `M_AXIS_TLAST`=1 on the beat where the counter equals `PACKET_LEN`-1, after which the counter wraps to 0. With `PACKET_LEN`=1, every beat has `TLAST`=1.
- Undefined: no beat counter; `M_AXIS_TLAST` is tied 0.

## Structure
- Shared package `time_stamp_tagger_pkg` holds:
  - the tag width constant (`TIME_STAMP_WIDTH+EVENT_CH_NUM`);
  - the `DROP_COUNT` width (16) and its saturation value;
  - the tag struct/typedef {mask, time}.
- One sub-module, `tag_fifo`: a synchronous FWFT FIFO with full/empty flags and occupancy. The top level holds edge detection, drop accounting and TLAST generation.

## Test plan
- Single event: `CURRENT_TIME`=0x100 in cycle c, `EVENT_IN[2]` 0→1, `TREADY`=1 → one beat in cycle c+1 with `TDATA`={0x04, 0x100}.
- Simultaneous channels: ch0 and ch5 rise together at time 0x200 → exactly one beat with mask 0x21 and time 0x200.
- Invalid time and held lines: rise while `CURRENT_TIME`=0 → no beat and `DROP_COUNT`=0. Lines held high across reset release → no beat.
- Overflow: `TREADY`=0, 20 separate rising edges with `FIFO_DEPTH`=16 → 16 tags buffered, `DROP_COUNT`=4, `OVERFLOW`=1. Then `TREADY`=1 → exactly 16 beats in order. A `CLEAR` pulse then returns both to 0.
- Backpressure: toggle `TREADY` randomly during a burst of 10 tags → `TDATA` stable while stalled, no loss, order preserved.
- Packet mode, with the macro defined and `PACKET_LEN`=4: 9 tags → `TLAST` on beats 4 and 8 only. Reset mid-burst → `TVALID`=0 next cycle and the beat counter restarts at 0.
